serial_pattern_tx: RTL and testbench



---
 rtl/serial_pattern_tx.sv | 184 ++++++++++++++++++
 tb/tb_serial_pattern_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// ---------------------------------------------------------------------------
// serial_pattern_tx
//
// Serial bit-pattern transmitter feeding the sequence-detector lab. A
// PAT_WIDTH-bit pattern is latched on start and shifted out MSB-first, one
// bit per advance, optionally repeated back-to-back (repeat_cnt extra
// frames). Everything runs in the system_clk domain.
//
// Advance source:
//   default build          : rising edges of the asynchronous 'step' input,
//                            through a 2-flop synchronizer plus edge register.
//   SERIAL_TX_AUTOSTEP_EN  : 'step' is ignored; an internal counter ticks
//                            every DIV system_clk cycles while in SEND.
//
// Ports:
//   system_clk   in   1          system clock, rising edge
//   reset        in   1          asynchronous, active-low, clears all state
//   step         in   1          debounced user clock (asynchronous)
//   start        in   1          level, sampled in IDLE only
//   abort        in   1          synchronous return to IDLE, beats step
//   use_default  in   1          1: load DEFAULT_PATTERN, 0: load pattern
//   pattern      in   PAT_WIDTH  user pattern, MSB sent first
//   repeat_cnt   in   4          extra frames (total = repeat_cnt + 1)
//   dout         out  1          serial data to the detector
//   busy         out  1          high while in SEND
//   done         out  1          one-cycle pulse when all frames are sent
//   leds         out  3          current bit index, 0 outside SEND
// ---------------------------------------------------------------------------
module serial_pattern_tx #(
  parameter int                   PAT_WIDTH       = 6,
  parameter logic [PAT_WIDTH-1:0] DEFAULT_PATTERN = 6'b101011,
  parameter int                   DIV             = 50_000_000
) (
  input  logic                 system_clk,
  input  logic                 reset,
  input  logic                 step,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 use_default,
  input  logic [PAT_WIDTH-1:0] pattern,
  input  logic [3:0]           repeat_cnt,
  output logic                 dout,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           leds
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(PAT_WIDTH - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PAT_WIDTH-1:0] r_pat;
  logic [PAT_WIDTH-1:0] w_pat_nxt;
  logic [PAT_WIDTH-1:0] r_shift;
  logic [PAT_WIDTH-1:0] w_shift_nxt;
  logic [2:0]           r_bit_cnt;
  logic [2:0]           w_bit_cnt_nxt;
  logic [3:0]           r_frames_left;
  logic [3:0]           w_frames_nxt;
  logic                 w_adv;
  logic [PAT_WIDTH-1:0] w_load_pat;

`ifdef SERIAL_TX_AUTOSTEP_EN
  // Tick counter: held at zero outside SEND so the first advance lands
  // exactly DIV cycles after the load edge; free-runs across repeat frames.
  localparam int              CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_tick_cnt;

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
    end else if (r_state != ST_SEND) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == CNT_MAX) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  assign w_adv = (r_state == ST_SEND) && (r_tick_cnt == CNT_MAX);
`else
  // Two synchronizer flops followed by an edge register; a single
  // advance is produced per rising edge no matter how long step stays high.
  logic r_step_s1;
  logic r_step_s2;
  logic r_step_s3;

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      r_step_s1 <= 1'b0;
      r_step_s2 <= 1'b0;
      r_step_s3 <= 1'b0;
    end else begin
      r_step_s1 <= step;
      r_step_s2 <= r_step_s1;
      r_step_s3 <= r_step_s2;
    end
  end

  assign w_adv = r_step_s2 & ~r_step_s3;
`endif

  assign w_load_pat = use_default ? DEFAULT_PATTERN : pattern;

  // State and datapath registers
  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_pat         <= '0;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_frames_left <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pat         <= w_pat_nxt;
      r_shift       <= w_shift_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_frames_left <= w_frames_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt   = r_state;
    w_pat_nxt     = r_pat;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_frames_nxt  = r_frames_left;

    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_pat_nxt     = w_load_pat;
            w_shift_nxt   = w_load_pat;
            w_bit_cnt_nxt = '0;
            w_frames_nxt  = repeat_cnt;
            w_state_nxt   = ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_adv) begin
            if (r_bit_cnt != LAST_BIT) begin
              w_shift_nxt   = {r_shift[PAT_WIDTH-2:0], 1'b0};
              w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end else if (r_frames_left != 4'd0) begin
              // Next frame's MSB follows immediately, no gap bit.
              w_shift_nxt   = r_pat;
              w_bit_cnt_nxt = '0;
              w_frames_nxt  = r_frames_left - 4'd1;
            end else begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // The MSB of the shift register is the bit on the wire; outside SEND the
  // line idles low.
  assign busy = (r_state == ST_SEND);
  assign done = (r_state == ST_DONE);
  assign dout = busy ? r_shift[PAT_WIDTH-1] : 1'b0;
  assign leds = busy ? r_bit_cnt : 3'd0;

endmodule

// File: tb/tb_serial_pattern_tx.sv
module tb_serial_pattern_tx;

  localparam int             W   = 6;
  localparam logic [W-1:0]   DEF = 6'b101011;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         step = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         use_default = 1'b0;
  logic [W-1:0] pattern = '0;
  logic [3:0]   repeat_cnt = '0;
  logic         dout;
  logic         busy;
  logic         done;
  logic [2:0]   leds;

  serial_pattern_tx dut (
    .system_clk  (clk),
    .reset       (rst_n),
    .step        (step),
    .start       (start),
    .abort       (abort),
    .use_default (use_default),
    .pattern     (pattern),
    .repeat_cnt  (repeat_cnt),
    .dout        (dout),
    .busy        (busy),
    .done        (done),
    .leds        (leds)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_done;
    logic       b;
    logic [2:0] idx;
  } tok_t;

  tok_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_adv = 0;
  logic mon_en = 1'b0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;
  logic [2:0] prev_leds = 3'd0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: a started sequence is just (rep+1) copies of the pattern,
  // MSB first, followed by one done event.
  task automatic push_seq(input logic [W-1:0] p, input int rep);
    tok_t t;
    for (int f = 0; f <= rep; f++) begin
      for (int i = W - 1; i >= 0; i--) begin
        t.is_done = 1'b0;
        t.b       = p[i];
        t.idx     = 3'(W - 1 - i);
        q.push_back(t);
      end
    end
    t.is_done = 1'b1;
    t.b       = 1'b0;
    t.idx     = 3'd0;
    q.push_back(t);
  endtask

  // Monitor: a new bit is presented whenever busy rises or leds moves.
  always @(negedge clk) begin
    tok_t t;
    if (mon_en) begin
      if (busy && (!prev_busy || leds != prev_leds)) begin
        n_adv++;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_bit got dout=%0b leds=%0d exp=nothing", dout, leds);
        end else begin
          t = q.pop_front();
          if (t.is_done || dout !== t.b || leds !== t.idx) begin
            failures++;
            $display("FAIL bit got dout=%0b leds=%0d exp dout=%0b leds=%0d done_tok=%0b",
                     dout, leds, t.b, t.idx, t.is_done);
          end
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (q.size() == 0 || !q[0].is_done || busy !== 1'b0 || dout !== 1'b0 || prev_done) begin
          failures++;
          $display("FAIL done_pulse got busy=%0b dout=%0b prev_done=%0b qsize=%0d exp=single_done_at_end",
                   busy, dout, prev_done, q.size());
        end else begin
          t = q.pop_front();
        end
      end
      if (busy !== 1'b1) begin
        checks++;
        if (dout !== 1'b0 || leds !== 3'd0) begin
          failures++;
          $display("FAIL idle_outputs got dout=%0b leds=%0d exp 0 0", dout, leds);
        end
      end
    end
    prev_busy = busy;
    prev_done = done;
    prev_leds = leds;
  end

  task automatic do_step(input int hi, input int lo);
    step = 1'b1;
    repeat (hi) @(negedge clk);
    step = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic rnd_step();
    do_step($urandom_range(1, 5), $urandom_range(3, 6));
  endtask

  task automatic load(input logic [W-1:0] p, input logic ud, input int rep);
    push_seq(ud ? DEF : p, rep);
    @(negedge clk);
    pattern     = p;
    use_default = ud;
    repeat_cnt  = 4'(rep);
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    // Later changes to the pattern inputs must not matter.
    pattern     = W'($urandom);
    use_default = 1'($urandom);
    repeat_cnt  = 4'($urandom);
  endtask

  task automatic finish_txn(input string name);
    repeat (8) @(negedge clk);
    check(name, q.size(), 0);
  endtask

  initial begin
    logic [W-1:0] p;
    int           rep;
    int           n0;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_dout", dout, 0);
    check("rst_done", done, 0);
    check("rst_leds", leds, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Default pattern, single frame, with step-to-advance latency check.
    load(6'h00, 1'b1, 0);
    step = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("lat_not_yet", leds, 0);
    @(negedge clk);
    check("lat_advanced", leds, 1);
    step = 1'b0;
    repeat (3) @(negedge clk);
    repeat (5) rnd_step();
    finish_txn("default_frame_drained");

    // Three contiguous copies of 110010.
    load(6'b110010, 1'b0, 2);
    repeat (18) rnd_step();
    finish_txn("repeat3_drained");

    // Long step high gives one advance; sub-cycle glitch gives none.
    load(6'b011101, 1'b0, 0);
    #1 n0 = n_adv;
    do_step(100, 4);
    #1 check("hold_one_adv", n_adv - n0, 1);
    n0 = n_adv;
    #1 step = 1'b1;
    #2 step = 1'b0;
    repeat (6) @(negedge clk);
    #1 check("glitch_no_adv", n_adv - n0, 0);
    repeat (5) rnd_step();
    finish_txn("hold_glitch_drained");

    // start and new pattern during SEND are ignored.
    load(6'b100110, 1'b0, 1);
    repeat (2) rnd_step();
    start       = 1'b1;
    pattern     = 6'b011001;
    use_default = 1'b1;
    repeat_cnt  = 4'd15;
    @(negedge clk);
    start = 1'b0;
    repeat (10) rnd_step();
    finish_txn("start_busy_drained");

    // abort on the same cycle as the step pulse at bit 4.
    load(6'h00, 1'b1, 0);
    repeat (4) rnd_step();
    check("abort_pre_leds", leds, 4);
    step = 1'b1;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    step  = 1'b0;
    q.delete();
    check("abort_busy", busy, 0);
    check("abort_dout", dout, 0);
    check("abort_leds", leds, 0);
    repeat (8) @(negedge clk);

    // Reset mid-frame after 3 bits, then restart from the MSB.
    load(6'b111000, 1'b0, 1);
    repeat (3) rnd_step();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_dout", dout, 0);
    check("midrst_leds", leds, 0);
    check("midrst_done", done, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    load(6'b101101, 1'b0, 0);
    repeat (6) rnd_step();
    finish_txn("post_reset_drained");

    // Randomized transactions.
    for (int n = 0; n < 8; n++) begin
      p   = W'($urandom);
      rep = $urandom_range(0, 3);
      load(p, 1'($urandom), rep);
      repeat ((rep + 1) * W) rnd_step();
      finish_txn("random_drained");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
